// File: rtl/mem_arbiter.sv
// Two-port arbiter that puts an instruction-fetch port and a load/store port onto one
// combinational-read memory. Data wins by default; fetch is forced through after STARVE_MAX data grants.
module mem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, LAST_IF, LAST_D} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  starve_reg, starve_next;
  logic        grant_if, grant_d;
  logic        if_addr_err, d_addr_err;
  logic [31:0] if_rdata_reg, d_rdata_reg;
  logic        if_err_reg, d_err_reg;

  assign if_addr_err = (|if_addr[31:ADDR_W]) | (|if_addr[1:0]);
  assign d_addr_err  = (|d_addr[31:ADDR_W])  | (|d_addr[1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      starve_reg <= 3'd0;
    end else begin
      state_reg  <= state_next;
      starve_reg <= starve_next;
    end
  end

  // The state is the previous cycle's grant, so it doubles as the response-valid flag.
  always_comb begin
    grant_if    = 1'b0;
    grant_d     = 1'b0;
    state_next  = IDLE;
    starve_next = starve_reg;
    if (d_req && if_req && starve_reg == 3'(STARVE_MAX))
      grant_if = 1'b1;
    else if (d_req)
      grant_d = 1'b1;
    else if (if_req)
      grant_if = 1'b1;

    if (grant_if)
      state_next = LAST_IF;
    else if (grant_d)
      state_next = LAST_D;

    if (!if_req || grant_if)
      starve_next = 3'd0;
    else if (grant_d)
      starve_next = starve_reg + 3'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_reg <= 32'd0;
      if_err_reg   <= 1'b0;
      d_rdata_reg  <= 32'd0;
      d_err_reg    <= 1'b0;
    end else begin
      if (grant_if) begin
        if_rdata_reg <= if_addr_err ? 32'd0 : mem_rdata;
        if_err_reg   <= if_addr_err;
      end
      if (grant_d) begin
        d_rdata_reg <= (d_we || d_addr_err) ? 32'd0 : mem_rdata;
        d_err_reg   <= d_addr_err;
      end
    end
  end

  // Grants and write strobes are gated by reset so they drop the instant reset asserts.
  assign if_gnt    = grant_if & rst;
  assign d_gnt     = grant_d & rst;
  assign if_rvalid = (state_reg == LAST_IF);
  assign d_rvalid  = (state_reg == LAST_D);
  assign if_rdata  = if_rdata_reg;
  assign if_err    = if_err_reg;
  assign d_rdata   = d_rdata_reg;
  assign d_err     = d_err_reg;

  assign mem_we    = rst & grant_d & d_we & ~d_addr_err;
  assign mem_be    = mem_we ? d_be : 4'b0000;
  assign mem_wdata = grant_d ? d_wdata : 32'd0;
  assign mem_addr  = grant_d  ? {d_addr[ADDR_W-1:2], 2'b00} :
                     grant_if ? {if_addr[ADDR_W-1:2], 2'b00} : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a byte-writable 4 KiB memory model plus hand-computed expectations.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be, mem_be;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem_model [0:1023];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(12), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem_model[mem_addr[11:2]];

  // Memory contents are (re)loaded while reset is held, otherwise byte-enabled writes.
  always @(posedge clk) begin
    if (!rst) begin
      for (int w = 0; w < 1024; w++) mem_model[w] <= 32'd0;
      mem_model[0] <= 32'h1111_1111;
      mem_model[2] <= 32'h00A0_0093;
      mem_model[4] <= 32'h1234_5678;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem_model[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b1; if_addr = 32'h8;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_be = 4'h0; d_wdata = 32'h0;

    // Reset state, with a fetch request already pending
    #3;
    chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);

    // Release mid-cycle; the very next edge grants the fetch
    #9; rst = 1'b1; #1;
    chk("fetch_gnt", {31'd0, if_gnt}, 32'd1);
    chk("fetch_maddr", {20'd0, mem_addr}, 32'h8);
    cyc();
    chk("fetch_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("fetch_rdata", if_rdata, 32'h00A0_0093);
    chk("fetch_err", {31'd0, if_err}, 32'd0);

    // Collision: data load wins
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; #1;
    chk("coll_d_gnt", {31'd0, d_gnt}, 32'd1);
    chk("coll_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("coll_maddr", {20'd0, mem_addr}, 32'h10);
    cyc();
    chk("coll_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("coll_d_rdata", d_rdata, 32'h1234_5678);
    chk("coll_if_rvalid", {31'd0, if_rvalid}, 32'd0);

    // Idle cycle: responses drop, data holds, starve counter clears
    if_req = 1'b0; d_req = 1'b0;
    cyc();
    chk("idle_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("hold_d_rdata", d_rdata, 32'h1234_5678);
    chk("hold_if_rdata", if_rdata, 32'h00A0_0093);

    // Starvation: D,D,D,D,IF,D
    if_req = 1'b1; if_addr = 32'h8; d_req = 1'b1; d_addr = 32'h10;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("starve_d%0d", i), {31'd0, d_gnt}, (i == 4) ? 32'd0 : 32'd1);
      chk($sformatf("starve_if%0d", i), {31'd0, if_gnt}, (i == 4) ? 32'd1 : 32'd0);
      if (i == 5) chk("starve_if_rv", {31'd0, if_rvalid}, 32'd1);
      cyc();
    end
    if_req = 1'b0; d_req = 1'b0;
    cyc();

    // Half-word store then back-to-back load of the same word
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_be = 4'b0011; d_wdata = 32'hDEAD_BEEF; #1;
    chk("st_mem_we", {31'd0, mem_we}, 32'd1);
    chk("st_mem_be", {28'd0, mem_be}, 32'h3);
    chk("st_maddr", {20'd0, mem_addr}, 32'h20);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    cyc();
    chk("st_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("st_err", {31'd0, d_err}, 32'd0);
    chk("st_rdata", d_rdata, 32'd0);
    d_we = 1'b0; #1;
    chk("ld_gnt_b2b", {31'd0, d_gnt}, 32'd1);
    cyc();
    chk("ld_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("ld_rdata", d_rdata, 32'h0000_BEEF);

    // Out-of-range store: no write, error response
    d_we = 1'b1; d_addr = 32'h1002; d_be = 4'hF; d_wdata = 32'hCAFE_F00D; #1;
    chk("err_st_gnt", {31'd0, d_gnt}, 32'd1);
    chk("err_st_we", {31'd0, mem_we}, 32'd0);
    chk("err_st_be", {28'd0, mem_be}, 32'd0);
    cyc();
    chk("err_st_err", {31'd0, d_err}, 32'd1);
    chk("err_st_rv", {31'd0, d_rvalid}, 32'd1);
    chk("err_st_rdata", d_rdata, 32'd0);
    chk("err_st_mem0", mem_model[0], 32'h1111_1111);

    // Misaligned fetch
    d_req = 1'b0; d_we = 1'b0; if_req = 1'b1; if_addr = 32'h6;
    cyc();
    if_req = 1'b0;
    chk("err_if_rv", {31'd0, if_rvalid}, 32'd1);
    chk("err_if_err", {31'd0, if_err}, 32'd1);
    chk("err_if_rdata", if_rdata, 32'd0);

    // Reset mid-operation: a granted load is cancelled
    d_req = 1'b1; d_addr = 32'h10;
    @(posedge clk);
    #3; rst = 1'b0; #1;
    chk("mid_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("mid_d_gnt", {31'd0, d_gnt}, 32'd0);
    chk("mid_d_rdata", d_rdata, 32'd0);
    chk("mid_if_err", {31'd0, if_err}, 32'd0);
    chk("mid_mem_be", {28'd0, mem_be}, 32'd0);
    d_req = 1'b0;
    cyc();
    #3; rst = 1'b1;
    cyc();
    chk("post_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("post_if_rvalid", {31'd0, if_rvalid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, byte-address width of the shared memory (4 KiB).
REQ-002 Parameter STARVE_MAX, default 4, consecutive data grants allowed while fetch waits.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 if_req  in  1  fetch request, held until granted.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_gnt  out  1  fetch granted this cycle (combinational).
REQ-008 if_rvalid  out  1  fetch response valid.
REQ-009 if_rdata  out  32  fetch word.
REQ-010 if_err  out  1  fetch error, qualified by if_rvalid.
REQ-011 d_req  in  1  data request, held until granted.
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_addr  in  32  data byte address.
REQ-014 d_be  in  4  store byte enables, bit i = byte addr+i.
REQ-015 d_wdata  in  32  store data, little-endian.
REQ-016 d_gnt  out  1  data granted this cycle (combinational).
REQ-017 d_rvalid  out  1  data response or store acknowledge valid.
REQ-018 d_rdata  out  32  load word.
REQ-019 d_err  out  1  data error, qualified by d_rvalid.
REQ-020 mem_addr  out  ADDR_W  word-aligned byte address to the memory.
REQ-021 mem_we  out  1  memory write strobe.
REQ-022 mem_be  out  4  memory byte enables.
REQ-023 mem_wdata  out  32  memory write data.
REQ-024 mem_rdata  in  32  memory read data, combinational from mem_addr.

Function
REQ-025 Exactly one requester SHALL be granted per cycle; the ungranted requester SHALL see gnt=0 and keep its request asserted.
REQ-026 The FSM SHALL have states IDLE, LAST_IF and LAST_D, recording the most recent grant; the state SHALL go to IDLE on a cycle with no grant.
REQ-027 Default priority SHALL be data over fetch.
REQ-028 A 3-bit starve counter SHALL increment on each d_gnt while if_req=1, clear on if_gnt, and clear when if_req=0.
REQ-029 When the starve counter equals STARVE_MAX and both requests are active, the fetch request SHALL be granted and the counter SHALL clear.
REQ-030 On a grant, the mux SHALL drive mem_addr = addr[ADDR_W-1:0] with bits[1:0] forced to 0 in the same cycle.
REQ-031 mem_we SHALL be 1 only for a granted, error-free store, with mem_be=d_be and mem_wdata=d_wdata; otherwise mem_we=0 and mem_be=0.
REQ-032 Response latency SHALL be exactly 1 cycle: rvalid asserts on the cycle after the grant, with rdata = mem_rdata captured at the grant edge.
REQ-033 A request SHALL be flagged as an error if addr[31:ADDR_W] is nonzero or addr[1:0] is nonzero.
REQ-034 For an error request, the block SHALL assert err=1 and rdata=0 in the response, and SHALL not write memory.
REQ-035 A store SHALL return d_rvalid=1, d_rdata=0 and d_err set per REQ-033.
REQ-036 rdata and err SHALL hold their last value when rvalid=0.
REQ-037 Back-to-back grants to the same requester SHALL be supported with no bubble.

Reset
REQ-038 On rst=0, the block SHALL immediately force all rvalid, err, gnt, mem_we and mem_be outputs to 0, rdata to 0, the state to IDLE and the starve counter to 0.
REQ-039 A transaction granted in the cycle before reset asserts SHALL produce no response after reset releases.
REQ-040 The first rising edge after rst returns to 1 SHALL already be able to grant.

Verification
REQ-041 Fetch only: if_req=1, if_addr=0x8, mem word 0x00A00093 -> if_gnt=1 the same cycle, then one cycle later if_rvalid=1 and if_rdata=0x00A00093.
REQ-042 Collision: if_req=d_req=1, d_we=0, d_addr=0x10 -> d_gnt=1 and if_gnt=0, then d_rvalid=1 one cycle later.
REQ-043 Starvation: d_req held high for 6 cycles with if_req high -> grants D,D,D,D,IF,D, starve counter 4 then 0.
REQ-044 Store: d_we=1, d_addr=0x20, d_be=4'b0011, d_wdata=0xDEADBEEF -> mem_we=1, mem_be=0011, d_rvalid=1, d_err=0; a later load from 0x20 returns the low half 0xBEEF.
REQ-045 Errors: d_addr=0x1002 store -> mem_we=0 and d_err=1; if_addr=0x6 -> if_err=1 and if_rdata=0.
REQ-046 Reset mid-operation: grant at cycle N, rst=0 at N+0.5 -> all outputs 0 immediately, and no rvalid after release.
